// File: rtl/ultra_pkg.sv
// Shared types and default timing for the ultrasonic trigger controllers (one per sensor side).
package ultra_pkg;

  localparam int unsigned TRIG_CYCLES_DEF      = 500;
  localparam int unsigned WAIT_RISE_CYCLES_DEF = 50_000;
  localparam int unsigned ECHO_MAX_CYCLES_DEF  = 1_500_000;
  localparam int unsigned PERIOD_CYCLES_DEF    = 3_000_000;
  localparam int unsigned CNT_W_DEF            = 22;
  localparam int unsigned STAT_W               = 16;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    ECHO_HIGH,
    HOLDOFF
  } state_e;

  // Outcome of the most recent frame's echo phase.
  typedef struct packed {
    logic no_echo;
    logic echo_timeout;
  } frame_status_t;

endpackage

// File: rtl/ultrasonic_trigger_ctrl_if.sv
// Sensor-side signals of one trigger controller. ULTRA_TRIG_STATS_EN adds the frame/fault counters.
interface ultrasonic_trigger_ctrl_if;
  import ultra_pkg::*;

  logic enable;
  logic echo;
  logic trig;
  logic busy;
  logic frame_done;
  logic no_echo;
  logic echo_timeout;
`ifdef ULTRA_TRIG_STATS_EN
  logic [STAT_W-1:0] frame_cnt;
  logic [STAT_W-1:0] fault_cnt;

  modport master (
    input  enable, echo,
    output trig, busy, frame_done, no_echo, echo_timeout, frame_cnt, fault_cnt
  );
  modport slave (
    output enable, echo,
    input  trig, busy, frame_done, no_echo, echo_timeout, frame_cnt, fault_cnt
  );
`else
  modport master (
    input  enable, echo,
    output trig, busy, frame_done, no_echo, echo_timeout
  );
  modport slave (
    output enable, echo,
    input  trig, busy, frame_done, no_echo, echo_timeout
  );
`endif

endinterface

// File: rtl/ultrasonic_trigger_ctrl_echo_sync.sv
// Two-flop synchronizer bringing the raw sensor echo into the clk domain.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], async_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/ultrasonic_trigger_ctrl.sv
// HC-SR04 trigger/echo supervisor: periodic trig pulse, echo rise/width watchdog, frame status.
// Optional macro ULTRA_TRIG_STATS_EN adds saturating frame_cnt/fault_cnt outputs.
module ultrasonic_trigger_ctrl
  import ultra_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES      = TRIG_CYCLES_DEF,
  parameter int unsigned WAIT_RISE_CYCLES = WAIT_RISE_CYCLES_DEF,
  parameter int unsigned ECHO_MAX_CYCLES  = ECHO_MAX_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES    = PERIOD_CYCLES_DEF,
  parameter int unsigned CNT_W            = CNT_W_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  ultrasonic_trigger_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_RISE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);

  // The whole frame must fit the period, and the period must fit the counters.
  if (PERIOD_CYCLES <= TRIG_CYCLES + WAIT_RISE_CYCLES + ECHO_MAX_CYCLES) begin : g_bad_timing
    $error("ultrasonic_trigger_ctrl: PERIOD_CYCLES too short for trig + wait + echo phases");
  end
  if ((64'(PERIOD_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
    $error("ultrasonic_trigger_ctrl: CNT_W cannot hold PERIOD_CYCLES");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  frame_status_t    status_q, status_d;
  logic             echo_s;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.echo),
    .sync_o  (echo_s)
  );

  // Next state, phase/period counters and registered-output targets.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    frame_done_d = 1'b0;
    phase_cnt_d  = phase_cnt_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = TRIG;
      end
      TRIG: begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
        if (phase_cnt_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
        if (echo_s) begin
          state_d = ECHO_HIGH;
        end else if (phase_cnt_q == WAIT_LAST) begin
          state_d               = HOLDOFF;
          frame_done_d          = 1'b1;
          status_d.no_echo      = 1'b1;
          status_d.echo_timeout = 1'b0;
        end
      end
      ECHO_HIGH: begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
        if (!echo_s) begin
          state_d      = HOLDOFF;
          frame_done_d = 1'b1;
          status_d     = '0;
        end else if (phase_cnt_q == ECHO_LAST) begin
          state_d               = HOLDOFF;
          frame_done_d          = 1'b1;
          status_d.no_echo      = 1'b0;
          status_d.echo_timeout = 1'b1;
        end
      end
      HOLDOFF: begin
        // A stuck-high echo holds off the next trig past the period boundary.
        if ((period_cnt_q == PERIOD_LAST) && !echo_s) begin
          state_d = bus.enable ? TRIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) phase_cnt_d = '0;

    if (state_q == IDLE) begin
      period_cnt_d = '0;
    end else if (period_cnt_q != PERIOD_LAST) begin
      period_cnt_d = period_cnt_q + CNT_W'(1);
    end
    if ((state_d == TRIG) && (state_q != TRIG)) period_cnt_d = '0;

    trig_d = (state_d == TRIG);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_cnt_q  <= '0;
      period_cnt_q <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      period_cnt_q <= period_cnt_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      status_q     <= status_d;
    end
  end

  assign bus.trig         = trig_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.no_echo      = status_q.no_echo;
  assign bus.echo_timeout = status_q.echo_timeout;

`ifdef ULTRA_TRIG_STATS_EN
  logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [STAT_W-1:0] fault_cnt_q, fault_cnt_d;

  // Counters advance together with the frame_done pulse and saturate.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (frame_done_d) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + STAT_W'(1);
      if ((status_d.no_echo || status_d.echo_timeout) && (fault_cnt_q != '1)) begin
        fault_cnt_d = fault_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_ultrasonic_trigger_ctrl.sv
// Bench for ultrasonic_trigger_ctrl with short timing: frame-time reference model plus directed checks.
module tb_ultrasonic_trigger_ctrl;

  localparam int TRIG_C   = 4;
  localparam int WAIT_C   = 20;
  localparam int ECHO_C   = 50;
  localparam int PERIOD_C = 100;

  logic clk;
  logic rst_n;
  ultrasonic_trigger_ctrl_if bus();

  ultrasonic_trigger_ctrl #(
    .TRIG_CYCLES      (TRIG_C),
    .WAIT_RISE_CYCLES (WAIT_C),
    .ECHO_MAX_CYCLES  (ECHO_C),
    .PERIOD_CYCLES    (PERIOD_C),
    .CNT_W            (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: time t counted from each trig rise, echo seen through two sample delays.
  bit m_in, m_ended, m_s1, m_s2;
  int m_t, m_rise;
  bit e_trig, e_busy, e_done, e_ne, e_et;
  int e_fc, e_flt;

  always @(posedge clk) begin : model
    bit es;
    bit fd;
    if (!rst_n) begin
      m_in = 0; m_ended = 0; m_s1 = 0; m_s2 = 0; m_t = 0; m_rise = -1;
      e_trig = 0; e_busy = 0; e_done = 0; e_ne = 0; e_et = 0; e_fc = 0; e_flt = 0;
    end else begin
      es = m_s2; m_s2 = m_s1; m_s1 = bus.echo;
      fd = 0;
      if (!m_in) begin
        if (bus.enable) begin m_in = 1; m_t = 0; m_rise = -1; m_ended = 0; end
      end else begin
        if (!m_ended && m_t >= TRIG_C) begin
          if (m_rise < 0) begin
            if (es) m_rise = m_t;
            else if (m_t == TRIG_C + WAIT_C - 1) begin fd = 1; e_ne = 1; e_et = 0; end
          end else if (!es) begin
            fd = 1; e_ne = 0; e_et = 0;
          end else if (m_t == m_rise + ECHO_C) begin
            fd = 1; e_ne = 0; e_et = 1;
          end
        end
        if (m_ended && m_t >= PERIOD_C - 1 && !es) begin
          if (bus.enable) begin m_t = 0; m_rise = -1; m_ended = 0; end
          else m_in = 0;
        end else begin
          m_t++;
        end
        if (fd) m_ended = 1;
      end
      e_done = fd;
      if (fd) begin
        if (e_fc < 65535) e_fc++;
        if ((e_ne || e_et) && e_flt < 65535) e_flt++;
      end
      e_trig = m_in && (m_t < TRIG_C);
      e_busy = m_in;
    end
  end

  // Per-cycle comparison against the model; everything must be 0 while reset is held.
  always @(negedge clk) begin
    check("cyc_trig",         int'(bus.trig),         rst_n ? int'(e_trig) : 0);
    check("cyc_busy",         int'(bus.busy),         rst_n ? int'(e_busy) : 0);
    check("cyc_frame_done",   int'(bus.frame_done),   rst_n ? int'(e_done) : 0);
    check("cyc_no_echo",      int'(bus.no_echo),      rst_n ? int'(e_ne)   : 0);
    check("cyc_echo_timeout", int'(bus.echo_timeout), rst_n ? int'(e_et)   : 0);
`ifdef ULTRA_TRIG_STATS_EN
    check("cyc_frame_cnt", int'(bus.frame_cnt), rst_n ? e_fc  : 0);
    check("cyc_fault_cnt", int'(bus.fault_cnt), rst_n ? e_flt : 0);
`endif
  end

  // Edge bookkeeping used by the directed checks.
  int n_rise = 0, n_fall = 0, n_done = 0;
  int last_rise = 0, last_fall = 0, last_done = 0;
  bit trig_prev = 0;

  always @(negedge clk) begin
    if (bus.trig && !trig_prev) begin n_rise++; last_rise = cyc; end
    if (!bus.trig && trig_prev) begin n_fall++; last_fall = cyc; end
    if (bus.frame_done) begin n_done++; last_done = cyc; end
    trig_prev = bus.trig;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0 rises, 1 falls, 2 frame_done pulses.
  task automatic wait_cnt(input int which, input int target, input int budget, input string name);
    int got;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #6;
      got = (which == 0) ? n_rise : (which == 1) ? n_fall : n_done;
      if (got >= target) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: event count %0d never reached %0d within %0d cycles", name, got, target, budget);
  endtask

  int r1, r4, d0, dr;
  int busy_seen;

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.echo = 1'b0;
    step(3);
    check("rst_trig", int'(bus.trig), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Good frame, then period measurement.
    bus.enable = 1'b1;
    rst_n = 1'b1;
    wait_cnt(0, 1, 10, "t1_rise");
    r1 = last_rise;
    wait_cnt(1, 1, 10, "t1_fall");
    check("t1_trig_width", last_fall - last_rise, 4);
    d0 = n_done;
    step(5); bus.echo = 1'b1;
    step(30); bus.echo = 1'b0;
    wait_cnt(0, 2, 120, "t1_rise2");
    check("t1_period", last_rise - r1, 100);
    check("t1_done_once", n_done - d0, 1);
    check("t1_no_echo", int'(bus.no_echo), 0);
    check("t1_timeout", int'(bus.echo_timeout), 0);

    // Missing echo, then a good frame clears the flag.
    wait_cnt(1, 2, 10, "t2_fall");
    d0 = n_done;
    wait_cnt(2, d0 + 1, 40, "t2_done");
    check("t2_done_latency", last_done - last_fall, 20);
    check("t2_no_echo", int'(bus.no_echo), 1);
    check("t2_timeout", int'(bus.echo_timeout), 0);
    wait_cnt(1, 3, 120, "t2b_fall");
    step(5); bus.echo = 1'b1;
    step(10); bus.echo = 1'b0;
    wait_cnt(2, d0 + 2, 40, "t2b_done");
    check("t2b_no_echo_cleared", int'(bus.no_echo), 0);

    // Echo stuck high 80 cycles: timeout, and trig held until echo drops.
    wait_cnt(0, 4, 120, "t3_rise");
    r4 = last_rise;
    wait_cnt(1, 4, 10, "t3_fall");
    step(15); bus.echo = 1'b1;
    step(80); bus.echo = 1'b0;
    check("t3_done_latency", last_done - last_fall, 68);
    check("t3_timeout", int'(bus.echo_timeout), 1);
    check("t3_no_echo", int'(bus.no_echo), 0);
    wait_cnt(0, 5, 30, "t3_rise_next");
    check("t3_withheld_period", last_rise - r4, 102);

    // enable dropped mid-echo: frame finishes, then idle.
    wait_cnt(1, 5, 10, "t4_fall");
    d0 = n_done;
    step(5); bus.echo = 1'b1;
    step(7); bus.enable = 1'b0;
    step(8); bus.echo = 1'b0;
    step(150);
    check("t4_done_once", n_done - d0, 1);
    check("t4_no_more_trig", n_rise, 5);
    check("t4_busy", int'(bus.busy), 0);
    check("t4_timeout_cleared", int'(bus.echo_timeout), 0);

    // Reset in the middle of a trig pulse.
    bus.enable = 1'b1;
    wait_cnt(0, 6, 5, "t5_rise");
    step(1);
    rst_n = 1'b0;
    #1;
    check("t5_async_trig", int'(bus.trig), 0);
    check("t5_async_busy", int'(bus.busy), 0);
    step(2);
    rst_n = 1'b1;
    dr = n_done;
    wait_cnt(0, 7, 5, "t5_rise_again");
    wait_cnt(1, 7, 10, "t5_fall_again");
    check("t5_trig_width", last_fall - last_rise, 4);

    // Three good frames and two without echo, the last one closing the run.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_cnt(1, 7 + i, 150, "t6_fall");
      if (i < 3) begin
        step(5); bus.echo = 1'b1;
        step(20); bus.echo = 1'b0;
      end
      if (i == 4) bus.enable = 1'b0;
    end
    busy_seen = 1;
    for (int i = 0; i < 200 && busy_seen != 0; i++) begin
      step(1);
      busy_seen = int'(bus.busy);
    end
    check("t6_idle", busy_seen, 0);
    check("t6_frames", n_done - dr, 5);
`ifdef ULTRA_TRIG_STATS_EN
    check("t6_frame_cnt", int'(bus.frame_cnt), 5);
    check("t6_fault_cnt", int'(bus.fault_cnt), 2);
`endif

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
